// File: rtl/display_pkg.sv
// Shared constants and scan-state encoding
// for the multiplexed 7-segment scan driver.
package display_pkg;

  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;
  localparam int IDX_W = $clog2(MAX_DIGITS);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_ON    = 1'b1
  } scan_st_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display_scan_prescaler.sv
// Slot prescaler: counts 0..SCAN_DIV-1 and
// flags slot start, guard end and terminal count.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_first,
  output logic o_guard_end,
  output logic o_tc
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] r_cnt;

  assign o_first     = (r_cnt == '0);
  assign o_guard_end = (r_cnt == CW'(GUARD - 1));
  assign o_tc        = (r_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed hex scan driver with guard band,
// frame-synchronous value commit and zero blanking.
module display_scan_driver
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS = 8,
  parameter  int SCAN_DIV   = 50000,
  parameter  int GUARD      = 4,
  localparam int DATA_W     = 4 * NUM_DIGITS,
  localparam int IW         = idx_w(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Load,
  input  logic [DATA_W-1:0]     Data_In,
  input  logic                  Blank_Lz,
  output logic [3:0]            Digit_Nibble,
  output logic [NUM_DIGITS-1:0] Anode_N,
  output logic [IW-1:0]         Digit_Idx,
  output logic                  Pending,
  output logic                  Frame_Done
);

  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] OFF =
    ANODE_OFF[NUM_DIGITS-1:0];

  logic w_first;
  logic w_ge;
  logic w_tc;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .GUARD    (GUARD)
  ) u_pre (
    .clk         (clk),
    .rst         (rst),
    .o_first     (w_first),
    .o_guard_end (w_ge),
    .o_tc        (w_tc)
  );

  scan_st_t              r_state;
  logic [IW-1:0]         r_idx;
  logic [3:0]            r_nib;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_pend;
  logic                  r_fd;
  logic                  r_blank;
  logic [DATA_W-1:0]     r_shadow;
  logic [DATA_W-1:0]     r_disp;

  logic                  w_wrap;
  logic [IW-1:0]         w_idx_nxt;
  logic [DATA_W-1:0]     w_disp_nxt;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  v_z;
  logic                  w_blank_calc;
  logic                  w_blank;

  assign w_wrap    = w_tc && (r_idx == LAST);
  assign w_idx_nxt = (r_idx == LAST) ? '0 : r_idx + 1'b1;

  // A load on the wrap cycle bypasses the shadow.
  always_comb begin
    w_disp_nxt = r_disp;
    if (w_wrap) begin
      if (Load) begin
        w_disp_nxt = Data_In;
      end else if (r_pend) begin
        w_disp_nxt = r_shadow;
      end
    end
  end

  // w_lz[i]: nibbles i..top of the display are all zero
  always_comb begin
    w_lz = '0;
    v_z  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_z     = v_z && (r_disp[4*i +: 4] == 4'h0);
      w_lz[i] = v_z;
    end
  end

  assign w_blank_calc = Blank_Lz && (r_idx != '0)
                        && w_lz[r_idx];
  assign w_blank = w_first ? w_blank_calc : r_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_GUARD;
      r_idx    <= '0;
      r_nib    <= 4'h0;
      r_an     <= OFF;
      r_pend   <= 1'b0;
      r_fd     <= 1'b0;
      r_blank  <= 1'b0;
      r_shadow <= '0;
      r_disp   <= '0;
    end else begin
      r_fd <= w_wrap;
      if (w_first) begin
        r_blank <= w_blank_calc;
      end
      if (w_wrap) begin
        r_disp <= w_disp_nxt;
        r_pend <= 1'b0;
      end else if (Load) begin
        r_shadow <= Data_In;
        r_pend   <= 1'b1;
      end
      if (w_tc) begin
        r_state <= ST_GUARD;
        r_an    <= OFF;
        r_idx   <= w_idx_nxt;
        r_nib   <= w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
      end else begin
        unique case (r_state)
          ST_GUARD: begin
            if (w_ge) begin
              r_state <= ST_ON;
              r_an    <= w_blank ? OFF :
                         ~(NUM_DIGITS'(1) << r_idx);
            end
          end
          ST_ON: begin
            r_state <= ST_ON;
          end
          default: begin
            r_state <= ST_GUARD;
          end
        endcase
      end
    end
  end

  assign Digit_Nibble = r_nib;
  assign Anode_N      = r_an;
  assign Digit_Idx    = r_idx;
  assign Pending      = r_pend;
  assign Frame_Done   = r_fd;

endmodule
